// File: rtl/mem_ctrl_rr.sv
// mem_ctrl_rr: round-robin arbitration of PORT_COUNT client ports onto a single packet link.
// Define MEM_CTRL_TIMEOUT_EN to abort reads that get no response within TIMEOUT_CYCLES.
module mem_ctrl_rr #(
  parameter  int PORT_COUNT      = 2,
  parameter  int DATA_WIDTH_BYTE = 4,
  parameter  int ADDR_WIDTH_BYTE = 4,
  parameter  int TIMEOUT_CYCLES  = 255,
  localparam int DATA_WIDTH      = 8 * DATA_WIDTH_BYTE,
  localparam int ADDR_WIDTH      = 8 * ADDR_WIDTH_BYTE,
  localparam int SEND_BYTE       = DATA_WIDTH_BYTE + ADDR_WIDTH_BYTE + 1,
  localparam int SEND_WIDTH      = 8 * SEND_BYTE
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  output logic                                  send_flag,
  output logic [SEND_WIDTH-1:0]                 send_data,
  output logic [4:0]                            send_length,
  output logic                                  recv_flag,
  input  logic [SEND_WIDTH-1:0]                 recv_data,
  input  logic [4:0]                            recv_length,
  input  logic                                  sendable,
  input  logic                                  receivable,
  input  logic [2*PORT_COUNT-1:0]               rw_flag_,
  input  logic [ADDR_WIDTH*PORT_COUNT-1:0]      addr_,
  input  logic [DATA_WIDTH*PORT_COUNT-1:0]      write_data_,
  input  logic [DATA_WIDTH_BYTE*PORT_COUNT-1:0] write_mask_,
  output logic [DATA_WIDTH*PORT_COUNT-1:0]      read_data_,
  output logic [PORT_COUNT-1:0]                 busy,
  output logic [PORT_COUNT-1:0]                 done,
  output logic [PORT_COUNT-1:0]                 err_
);

  localparam int PW = $clog2(PORT_COUNT);

  typedef enum logic {S_IDLE, S_WAIT_RECV} state_t;

  state_t                       r_state, w_state_nxt;
  logic [PORT_COUNT-1:0]        r_busy, r_req_wr, w_capture;
  logic [ADDR_WIDTH-1:0]        r_req_addr [PORT_COUNT];
  logic [DATA_WIDTH-1:0]        r_req_data [PORT_COUNT];
  logic [DATA_WIDTH_BYTE-1:0]   r_req_mask [PORT_COUNT];
  logic [PW-1:0]                r_last_grant, r_owner, w_grant_idx;
  logic                         w_grant_vld, w_do_send, w_do_recv;
  logic                         r_send_flag, r_recv_flag;
  logic [SEND_WIDTH-1:0]        r_send_data, w_wr_pkt, w_rd_pkt;
  logic [4:0]                   r_send_length;
  logic [PORT_COUNT-1:0]        r_done;
  logic [DATA_WIDTH*PORT_COUNT-1:0] r_read_data;

  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      w_capture[p] = !r_busy[p] && (rw_flag_[2*p +: 2] == 2'd1 || rw_flag_[2*p +: 2] == 2'd2);
    end
  end

  // Walk offsets from farthest to nearest so the port closest after last_grant wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = PORT_COUNT; i >= 1; i--) begin
      if (r_busy[PW'((int'(r_last_grant) + i) % PORT_COUNT)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = PW'((int'(r_last_grant) + i) % PORT_COUNT);
      end
    end
  end

  assign w_wr_pkt = {8'h80 | 8'(r_req_mask[w_grant_idx]), r_req_addr[w_grant_idx],
                     r_req_data[w_grant_idx]};
  assign w_rd_pkt = SEND_WIDTH'({8'h00, r_req_addr[w_grant_idx]});

`ifdef MEM_CTRL_TIMEOUT_EN
  logic [15:0]           r_tmo_cnt;
  logic [PORT_COUNT-1:0] r_err;
  logic                  w_do_tmo;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_do_send   = 1'b0;
    w_do_recv   = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
    w_do_tmo    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (sendable && w_grant_vld) begin
          w_do_send = 1'b1;
          if (!r_req_wr[w_grant_idx]) w_state_nxt = S_WAIT_RECV;
        end
      end
      S_WAIT_RECV: begin
        if (receivable) begin
          w_do_recv   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef MEM_CTRL_TIMEOUT_EN
        else if (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          w_do_tmo    = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: request payload needs no reset; it is only consumed while its busy bit is set.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (w_capture[p]) begin
        r_req_wr[p]   <= rw_flag_[2*p+1];
        r_req_addr[p] <= addr_[p*ADDR_WIDTH +: ADDR_WIDTH];
        r_req_data[p] <= write_data_[p*DATA_WIDTH +: DATA_WIDTH];
        r_req_mask[p] <= write_mask_[p*DATA_WIDTH_BYTE +: DATA_WIDTH_BYTE];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy        <= '0;
      r_last_grant  <= PW'(PORT_COUNT - 1);
      r_owner       <= '0;
      r_send_flag   <= 1'b0;
      r_send_data   <= '0;
      r_send_length <= '0;
      r_recv_flag   <= 1'b0;
      r_done        <= '0;
      r_read_data   <= '0;
    end else begin
      r_send_flag <= 1'b0;
      r_recv_flag <= 1'b0;
      r_done      <= '0;
      // Capture only targets idle ports and completion only busy ones, so they never collide.
      r_busy      <= r_busy | w_capture;
      if (w_do_send) begin
        r_send_flag  <= 1'b1;
        r_last_grant <= w_grant_idx;
        r_owner      <= w_grant_idx;
        if (r_req_wr[w_grant_idx]) begin
          r_send_data           <= w_wr_pkt;
          r_send_length         <= 5'(SEND_BYTE);
          r_done[w_grant_idx]   <= 1'b1;
          r_busy[w_grant_idx]   <= 1'b0;
        end else begin
          r_send_data           <= w_rd_pkt;
          r_send_length         <= 5'(ADDR_WIDTH_BYTE + 1);
        end
      end
      if (w_do_recv) begin
        r_recv_flag <= 1'b1;
        r_read_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH] <= recv_data[DATA_WIDTH-1:0];
        r_done[r_owner] <= 1'b1;
        r_busy[r_owner] <= 1'b0;
      end
`ifdef MEM_CTRL_TIMEOUT_EN
      if (w_do_tmo) begin
        r_read_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH] <= '0;
        r_done[r_owner] <= 1'b1;
        r_busy[r_owner] <= 1'b0;
      end
`endif
    end
  end

`ifdef MEM_CTRL_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tmo_cnt <= '0;
      r_err     <= '0;
    end else begin
      r_err <= '0;
      if (w_do_send)                   r_tmo_cnt <= '0;
      else if (r_state == S_WAIT_RECV) r_tmo_cnt <= r_tmo_cnt + 16'd1;
      if (w_do_tmo) r_err[r_owner] <= 1'b1;
    end
  end
  assign err_ = r_err;
`else
  assign err_ = '0;
`endif

  logic w_unused;
  assign w_unused = ^{recv_length, recv_data[SEND_WIDTH-1:DATA_WIDTH], 16'(TIMEOUT_CYCLES)};

  assign send_flag   = r_send_flag;
  assign send_data   = r_send_data;
  assign send_length = r_send_length;
  assign recv_flag   = r_recv_flag;
  assign read_data_  = r_read_data;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: doc/mem_ctrl_rr.md
MEM_CTRL_RR -- requirements
Module: mem_ctrl_rr

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of CLK only.
REQ-002 Parameter PORT_COUNT, default 2, SHALL set the number of client ports (2..8).
REQ-003 Parameter DATA_WIDTH_BYTE, default 4, SHALL set the data bytes per access (1, 2 or 4); DATA_WIDTH = 8*DATA_WIDTH_BYTE.
REQ-004 Parameter ADDR_WIDTH_BYTE, default 4, SHALL set the address bytes (1..4); ADDR_WIDTH = 8*ADDR_WIDTH_BYTE.
REQ-005 Parameter TIMEOUT_CYCLES, default 255, SHALL set the read-response timeout in cycles (1..65535); it is used only when MEM_CTRL_TIMEOUT_EN is defined.
REQ-006 Derived value SEND_BYTE = DATA_WIDTH_BYTE + ADDR_WIDTH_BYTE + 1.
REQ-007 Ports SHALL be:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
send_flag  out  1  one-cycle pulse: send_data/send_length valid
send_data  out  SEND_BYTE*8  outgoing packet, LSB-aligned
send_length  out  5  packet length in bytes
recv_flag  out  1  one-cycle pulse: consume the current receive packet
recv_data  in  SEND_BYTE*8  incoming packet; data in [DATA_WIDTH-1:0]
recv_length  in  5  incoming length; ignored
sendable  in  1  the link can accept a packet this cycle
receivable  in  1  a receive packet is available
rw_flag_  in  2*PORT_COUNT  per port: 0 none, 1 read, 2 write, 3 ignored
addr_  in  ADDR_WIDTH*PORT_COUNT  per-port address
write_data_  in  DATA_WIDTH*PORT_COUNT  per-port write data
write_mask_  in  DATA_WIDTH_BYTE*PORT_COUNT  per-port byte enables
read_data_  out  DATA_WIDTH*PORT_COUNT  per-port last read result
busy  out  PORT_COUNT  port holds a captured or in-flight request
done  out  PORT_COUNT  one-cycle completion pulse
err_  out  PORT_COUNT  one-cycle timeout pulse, coincident with done

Function
REQ-008 Capture: port p with rw_flag 1 or 2 and busy[p]=0 SHALL latch flag, addr, data and mask, and SHALL set busy[p]=1 at the next edge; requests while busy[p]=1, and rw_flag=3, SHALL be ignored.
REQ-009 States SHALL be IDLE and WAIT_RECV.
REQ-010 In IDLE with sendable=1 and at least one captured request, the block SHALL grant round-robin, searching from last_grant+1 modulo PORT_COUNT; last_grant SHALL update to the granted port.
REQ-011 A read grant SHALL drive send_data = {8'h00, addr}, send_length = ADDR_WIDTH_BYTE+1 and send_flag=1 for one cycle, then enter WAIT_RECV.
REQ-012 A write grant SHALL drive send_data = {8'h80 | mask, addr, data}, send_length = SEND_BYTE and send_flag=1, and in the same cycle SHALL pulse done[p], clear busy[p] and remain in IDLE.
REQ-013 Minimum latency SHALL be 2 cycles from rw_flag sampled to send_flag=1; there is no bypass.
REQ-014 In WAIT_RECV with receivable=1, the block SHALL pulse recv_flag, load read_data[p] with recv_data[DATA_WIDTH-1:0], pulse done[p], clear busy[p] and return to IDLE.
REQ-015 At most one packet SHALL be in flight; capture on other ports SHALL continue during WAIT_RECV.
REQ-016 send_data and send_length SHALL hold their last values between pulses.
REQ-017 read_data[p] SHALL change only on completion of a read for port p.

Reset
REQ-018 While RST=1, all outputs SHALL be 0, state SHALL be IDLE, every captured request SHALL be discarded and last_grant SHALL be PORT_COUNT-1, so that port 0 wins first.
REQ-019 A reset during WAIT_RECV SHALL abandon the read with no done pulse and no recv_flag pulse.

Configuration
REQ-020 With MEM_CTRL_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles in WAIT_RECV. On reaching TIMEOUT_CYCLES with receivable=0, the block SHALL pulse done[p] and err_[p], set read_data[p]=0, clear busy[p] and return to IDLE. If receivable=1 in that same cycle, the normal receive SHALL win.
REQ-021 Without MEM_CTRL_TIMEOUT_EN, WAIT_RECV SHALL wait indefinitely and err_ SHALL be constant 0.

Verification
REQ-022 Port0 read 0x00001000, sendable=1, receivable two cycles after send with data 0xDEADBEEF -> send_data=0x0000001000, length 5, recv_flag, done[0], read_data[0]=0xDEADBEEF.
REQ-023 Port1 write addr 0x20, data 0x11223344, mask 0xF -> send_data=0x8F0000002011223344, length 9, done[1] on the same cycle as send_flag, busy[1]=0.
REQ-024 Both ports issue writes every cycle while sendable=1 -> grants alternate 0,1,0,1 with no starvation.
REQ-025 sendable=0 for 10 cycles with port0 pending -> no send_flag, busy[0]=1 throughout; the send occurs on the first sendable=1 cycle.
REQ-026 With MEM_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=4, a read with receivable=0 -> done[0] and err_[0] 4 cycles after send, read_data[0]=0; RST asserted mid-WAIT_RECV in a second run -> no done and all outputs 0.
